// File: rtl/cpu_trace_formatter_pkg.sv
// cpu_trace_pkg: shared constants, FSM state encoding and the hex-nibble to
// ASCII helper for the CPU trace-line formatter.
//
// Contents:
//   ASCII_*    character codes used to build a trace line
//   KIND_*     record kind encoding (register write / memory write)
//   state_t    formatter FSM states, one per emitted character or field
//   hex_ascii  4-bit value -> '0'..'9' / 'a'..'f'
package cpu_trace_pkg;

    localparam logic [7:0] ASCII_CARET  = 8'h5E; // '^'
    localparam logic [7:0] ASCII_AT     = 8'h40; // '@'
    localparam logic [7:0] ASCII_COLON  = 8'h3A; // ':'
    localparam logic [7:0] ASCII_SPACE  = 8'h20; // ' '
    localparam logic [7:0] ASCII_DOLLAR = 8'h24; // '$'
    localparam logic [7:0] ASCII_STAR   = 8'h2A; // '*'
    localparam logic [7:0] ASCII_LT     = 8'h3C; // '<'
    localparam logic [7:0] ASCII_EQ     = 8'h3D; // '='
    localparam logic [7:0] ASCII_HASH   = 8'h23; // '#'
    localparam logic [7:0] ASCII_0      = 8'h30; // '0'
    localparam logic [7:0] ASCII_A      = 8'h61; // 'a' (lowercase only)

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    // Sixteen states exactly fill the 4-bit encoding.
    typedef enum logic [3:0] {
        S_IDLE,
        S_CARET,
        S_TIME,
        S_AT,
        S_PC,
        S_COLON,
        S_SP1,
        S_KIND,
        S_REGD,
        S_ADDR,
        S_SP2,
        S_LT,
        S_EQ,
        S_SP3,
        S_DATA,
        S_HASH
    } state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + 8'(nib);
        end
        return ASCII_A + 8'(nib) - 8'd10;
    endfunction

endpackage

// File: rtl/cpu_trace_formatter_bin2bcd.sv
// trace_bin2bcd: combinational binary to BCD converter (double dabble).
// The input is first clamped to 9999 so the result always fits in four
// decimal digits.
//
// Ports:
//   bin   in   14  unsigned binary value
//   bcd   out  16  four BCD digits, digit 3 (thousands) in [15:12]
//   ndig  out  3   number of significant digits, 1..4 (value 0 -> 1)
module trace_bin2bcd (
    input  logic [13:0] bin,
    output logic [15:0] bcd,
    output logic [2:0]  ndig
);

    logic [13:0] sat;
    assign sat = (bin > 14'd9999) ? 14'd9999 : bin;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // stage[k] holds the BCD accumulator after k input bits were shifted in.
    logic [15:0] stage [0:14];
    assign stage[0] = '0;

    generate
        for (genvar gi = 0; gi < 14; gi++) begin : g_shift
            logic [3:0] a0;
            logic [3:0] a1;
            logic [3:0] a2;
            logic [2:0] a3;
            assign a0 = add3(stage[gi][3:0]);
            assign a1 = add3(stage[gi][7:4]);
            assign a2 = add3(stage[gi][11:8]);
            // The thousands digit can never exceed 4 before a shift because
            // the value is clamped to 9999, so its top bit is shifted out as 0.
            assign a3 = 3'(add3(stage[gi][15:12]));
            assign stage[gi+1] = {a3, a2, a1, a0, sat[13-gi]};
        end
    endgenerate

    assign bcd = stage[14];

    always_comb begin
        if (bcd[15:12] != 4'd0) begin
            ndig = 3'd4;
        end else if (bcd[11:8] != 4'd0) begin
            ndig = 3'd3;
        end else if (bcd[7:4] != 4'd0) begin
            ndig = 3'd2;
        end else begin
            ndig = 3'd1;
        end
    end

endmodule

// File: rtl/cpu_trace_formatter.sv
// cpu_trace_formatter: serializes one CPU write-back record as an ASCII trace
// line, one character per output handshake:
//   "^<time>@<pc>: $<reg> <= <data>#"   (register write)
//   "^<time>@<pc>: *<addr> <= <data>#"  (memory write)
// Time is decimal clamped to 9999, reg is decimal, hex fields are 8 lowercase
// digits.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   in_valid/in_ready  record handshake; all in_* fields latch on accept
//   in_kind            0 = register write, 1 = memory write
//   in_time            time stamp (TIME_W bits)
//   in_pc, in_addr     instruction / memory address
//   in_reg             destination register (REG_W bits)
//   in_data            written value
//   char_out/char_valid/char_ready  character stream handshake
//   busy               line in progress
//   line_done          pulse in the cycle '#' is accepted
module cpu_trace_formatter
    import cpu_trace_pkg::*;
#(
    parameter int TIME_W = 14,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_kind,
    input  logic [TIME_W-1:0] in_time,
    input  logic [31:0]       in_pc,
    input  logic [REG_W-1:0]  in_reg,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_data,
    output logic [7:0]        char_out,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              busy,
    output logic              line_done
);

    state_t            state_reg, state_next;
    logic [3:0]        idx_reg, idx_next;

    logic              kind_reg;
    logic [TIME_W-1:0] time_reg;
    logic [31:0]       pc_reg;
    logic [REG_W-1:0]  reg_reg;
    logic [31:0]       addr_reg;
    logic [31:0]       data_reg;

    logic              active;
    logic              ready_int;
    logic              fire;
    logic              accept;
    logic              last;
    logic [7:0]        ch;

    // ------------------------------------------------------------------
    // Decimal conversion of the latched time stamp and register number
    // ------------------------------------------------------------------
    logic [13:0] time_bin;
    logic [13:0] reg_bin;
    logic [15:0] time_bcd;
    logic [15:0] reg_bcd;
    logic [2:0]  time_nd;
    logic [2:0]  reg_nd;

    assign time_bin = (32'(time_reg) > 32'd9999) ? 14'd9999 : 14'(time_reg);
    assign reg_bin  = 14'(reg_reg);

    trace_bin2bcd u_time_bcd (
        .bin  (time_bin),
        .bcd  (time_bcd),
        .ndig (time_nd)
    );

    trace_bin2bcd u_reg_bcd (
        .bin  (reg_bin),
        .bcd  (reg_bcd),
        .ndig (reg_nd)
    );

    // Digit 'sel' of an nd-digit decimal number, most significant first.
    function automatic logic [3:0] dec_digit(input logic [15:0] bcd,
                                             input logic [2:0]  nd,
                                             input logic [1:0]  sel);
        logic [1:0] pos;
        pos = 2'(nd - 3'd1) - sel;
        return bcd[{pos, 2'b00} +: 4];
    endfunction

    // Nibble 'sel' of a 32-bit word, bits [31:28] first.
    function automatic logic [3:0] hex_nibble(input logic [31:0] word,
                                              input logic [2:0]  sel);
        return word[{~sel, 2'b00} +: 4];
    endfunction

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign active    = (state_reg != S_IDLE);
    assign ready_int = (state_reg == S_IDLE) || ((state_reg == S_HASH) && char_ready);
    assign fire      = active && char_ready;
    assign accept    = in_valid && ready_int;

    // Outputs are forced quiet for as long as reset is held.
    assign in_ready   = !reset && ready_int;
    assign char_valid = !reset && active;
    assign busy       = !reset && active;
    assign line_done  = !reset && (state_reg == S_HASH) && char_ready;
    assign char_out   = reset ? 8'h00 : ch;

    // ------------------------------------------------------------------
    // Record latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            kind_reg <= KIND_REG;
            time_reg <= '0;
            pc_reg   <= '0;
            reg_reg  <= '0;
            addr_reg <= '0;
            data_reg <= '0;
        end else if (accept) begin
            kind_reg <= in_kind;
            time_reg <= in_time;
            pc_reg   <= in_pc;
            reg_reg  <= in_reg;
            addr_reg <= in_addr;
            data_reg <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            idx_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        ch         = 8'h00;
        // Single-character states are always on their last (only) character.
        last       = 1'b1;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_CARET;
                end
            end
            S_CARET: begin
                ch = ASCII_CARET;
                if (fire) state_next = S_TIME;
            end
            S_TIME: begin
                ch   = hex_ascii(dec_digit(time_bcd, time_nd, idx_reg[1:0]));
                last = (idx_reg == 4'(time_nd) - 4'd1);
                if (fire && last) state_next = S_AT;
            end
            S_AT: begin
                ch = ASCII_AT;
                if (fire) state_next = S_PC;
            end
            S_PC: begin
                ch   = hex_ascii(hex_nibble(pc_reg, idx_reg[2:0]));
                last = (idx_reg == 4'd7);
                if (fire && last) state_next = S_COLON;
            end
            S_COLON: begin
                ch = ASCII_COLON;
                if (fire) state_next = S_SP1;
            end
            S_SP1: begin
                ch = ASCII_SPACE;
                if (fire) state_next = S_KIND;
            end
            S_KIND: begin
                ch = (kind_reg == KIND_MEM) ? ASCII_STAR : ASCII_DOLLAR;
                if (fire) state_next = (kind_reg == KIND_MEM) ? S_ADDR : S_REGD;
            end
            S_REGD: begin
                ch   = hex_ascii(dec_digit(reg_bcd, reg_nd, idx_reg[1:0]));
                last = (idx_reg == 4'(reg_nd) - 4'd1);
                if (fire && last) state_next = S_SP2;
            end
            S_ADDR: begin
                ch   = hex_ascii(hex_nibble(addr_reg, idx_reg[2:0]));
                last = (idx_reg == 4'd7);
                if (fire && last) state_next = S_SP2;
            end
            S_SP2: begin
                ch = ASCII_SPACE;
                if (fire) state_next = S_LT;
            end
            S_LT: begin
                ch = ASCII_LT;
                if (fire) state_next = S_EQ;
            end
            S_EQ: begin
                ch = ASCII_EQ;
                if (fire) state_next = S_SP3;
            end
            S_SP3: begin
                ch = ASCII_SPACE;
                if (fire) state_next = S_DATA;
            end
            S_DATA: begin
                ch   = hex_ascii(hex_nibble(data_reg, idx_reg[2:0]));
                last = (idx_reg == 4'd7);
                if (fire && last) state_next = S_HASH;
            end
            S_HASH: begin
                ch = ASCII_HASH;
                // A record accepted together with '#' starts the next line
                // immediately, without passing through IDLE.
                if (fire) state_next = accept ? S_CARET : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Digit index steps within a field and restarts at 0 for the next one.
        if (fire) begin
            idx_next = last ? 4'd0 : idx_reg + 4'd1;
        end
    end

endmodule

// File: tb/tb_cpu_trace_formatter.sv
// Testbench for cpu_trace_formatter: table-driven directed lines, back-to-back
// records, randomized records under random backpressure checked against a
// string-formatting reference model, and reset in the middle of a line.
module tb_cpu_trace_formatter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_kind;
    logic [13:0] in_time;
    logic [31:0] in_pc;
    logic [4:0]  in_reg;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;
    logic        busy;
    logic        line_done;

    always #5 clk = ~clk;

    cpu_trace_formatter #(.TIME_W(14), .REG_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_time    (in_time),
        .in_pc      (in_pc),
        .in_reg     (in_reg),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .busy       (busy),
        .line_done  (line_done)
    );

    typedef struct {
        logic        kind;
        logic [13:0] tm;
        logic [31:0] pc;
        logic [4:0]  rg;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    typedef struct {
        rec_t  rec;
        string exp;
    } vec_t;

    typedef struct {
        string text;
        int    first_cyc;
        int    hash_cyc;
    } line_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    rand_ready = 1'b0;
    line_t got_lines[$];
    string cur = "";
    int    cur_first = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Sink-side readiness, changed just after each active edge.
    initial begin
        char_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            char_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Reference model: the line the specification requires for a record.
    function automatic string fmt_line(input rec_t r);
        int unsigned t;
        t = (r.tm > 14'd9999) ? 9999 : int'(r.tm);
        if (r.kind == 1'b0)
            return $sformatf("^%0d@%08h: $%0d <= %08h#", t, r.pc, r.rg, r.data);
        return $sformatf("^%0d@%08h: *%08h <= %08h#", t, r.pc, r.addr, r.data);
    endfunction

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_str(input string name, input string got, input string exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
        end
    endtask

    // Output stream monitor: assembles lines and checks handshake rules.
    initial begin
        bit         prev_stall;
        logic [7:0] prev_char;
        bit         exp_done;
        bit         exp_rdy;
        prev_stall = 1'b0;
        prev_char  = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                cur        = "";
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (char_valid !== 1'b1 || char_out !== prev_char) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%0b char=%h expected valid=1 char=%h",
                                 char_valid, char_out, prev_char);
                    end
                end
                exp_done = char_valid && char_ready && (char_out == 8'h23);
                checks++;
                if (line_done !== exp_done) begin
                    errors++;
                    $display("FAIL line_done: got %0b expected %0b at cycle %0d", line_done, exp_done, cyc);
                end
                exp_rdy = !char_valid || (char_ready && (char_out == 8'h23));
                checks++;
                if (in_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL in_ready: got %0b expected %0b at cycle %0d", in_ready, exp_rdy, cyc);
                end
                checks++;
                if (busy !== char_valid) begin
                    errors++;
                    $display("FAIL busy: got %0b expected %0b at cycle %0d", busy, char_valid, cyc);
                end
                if (char_valid && char_ready) begin
                    if (cur.len() == 0) cur_first = cyc;
                    cur = $sformatf("%s%c", cur, char_out);
                    if (char_out == 8'h23) begin
                        got_lines.push_back('{cur, cur_first, cyc});
                        cur = "";
                    end
                end
                prev_stall = char_valid && !char_ready;
                prev_char  = char_out;
            end
        end
    end

    task automatic drive(input rec_t r);
        in_kind = r.kind;
        in_time = r.tm;
        in_pc   = r.pc;
        in_reg  = r.rg;
        in_addr = r.addr;
        in_data = r.data;
    endtask

    task automatic scramble();
        in_kind = 1'($urandom);
        in_time = 14'($urandom);
        in_pc   = $urandom;
        in_reg  = 5'($urandom);
        in_addr = $urandom;
        in_data = $urandom;
    endtask

    // Offer a record; acc is the cycle whose closing edge accepted it.
    task automatic send(input rec_t r, input bit hold, output int acc);
        drive(r);
        in_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=0 after 500 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            in_valid = 1'b0;
            scramble();
        end
    endtask

    task automatic get_line(output line_t l, output bit ok);
        ok = 1'b0;
        l  = '{"", 0, 0};
        for (int i = 0; i < 600; i++) begin
            if (got_lines.size() > 0) begin
                l  = got_lines.pop_front();
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        #1;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL line_timeout: no complete line after 600 cycles, expected one");
        end
    endtask

    function automatic rec_t rand_rec();
        rec_t r;
        r.kind = 1'($urandom);
        case ($urandom_range(0, 3))
            0:       r.tm = 14'($urandom_range(0, 9));
            1:       r.tm = 14'($urandom_range(0, 9999));
            2:       r.tm = 14'($urandom_range(10000, 16383));
            default: r.tm = 14'($urandom_range(0, 16383));
        endcase
        r.pc   = $urandom;
        r.rg   = 5'($urandom_range(0, 31));
        r.addr = $urandom;
        r.data = $urandom;
        return r;
    endfunction

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        line_t l, l1, l2;
        bit    ok, ok1, ok2;
        int    acc, acc1, acc2;
        rec_t  r;

        vecs[0] = '{'{1'b0, 14'd5,     32'h00003000, 5'd3,  32'h0,        32'h0000abcd},
                    "^5@00003000: $3 <= 0000abcd#"};
        vecs[1] = '{'{1'b1, 14'd1234,  32'h00003004, 5'd0,  32'h00000010, 32'hFFFFFFFF},
                    "^1234@00003004: *00000010 <= ffffffff#"};
        vecs[2] = '{'{1'b0, 14'd0,     32'h00003008, 5'd31, 32'h0,        32'h12345678},
                    "^0@00003008: $31 <= 12345678#"};
        vecs[3] = '{'{1'b0, 14'd12000, 32'hDEADBEEF, 5'd0,  32'h0,        32'h00000000},
                    "^9999@deadbeef: $0 <= 00000000#"};
        vecs[4] = '{'{1'b1, 14'd9999,  32'hA5A5A5A5, 5'd7,  32'hCAFEF00D, 32'h89ABCDEF},
                    "^9999@a5a5a5a5: *cafef00d <= 89abcdef#"};
        vecs[5] = '{'{1'b1, 14'd16383, 32'h00000000, 5'd1,  32'hFFFFFFFF, 32'h00000001},
                    "^9999@00000000: *ffffffff <= 00000001#"};
        vecs[6] = '{'{1'b0, 14'd10,    32'h00000010, 5'd10, 32'h0,        32'h00000100},
                    "^10@00000010: $10 <= 00000100#"};
        vecs[7] = '{'{1'b0, 14'd999,   32'h7FFFFFFF, 5'd9,  32'h0,        32'h80000000},
                    "^999@7fffffff: $9 <= 80000000#"};

        // Reset state, with a record offered during reset.
        reset    = 1'b1;
        in_valid = 1'b1;
        drive(vecs[0].rec);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_int("reset_char_valid", int'(char_valid), 0);
        chk_int("reset_char_out",   int'(char_out),   0);
        chk_int("reset_busy",       int'(busy),       0);
        chk_int("reset_line_done",  int'(line_done),  0);
        chk_int("reset_in_ready",   int'(in_ready),   0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_int("idle_in_ready", int'(in_ready), 1);

        // Directed table, sink always ready: exact text, latency, no gaps.
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].rec, 1'b0, acc);
            get_line(l, ok);
            if (ok) begin
                chk_str($sformatf("vec%0d_text", i), l.text, vecs[i].exp);
                chk_int($sformatf("vec%0d_latency", i), l.first_cyc, acc + 1);
                chk_int($sformatf("vec%0d_contiguous", i), l.hash_cyc - l.first_cyc,
                        vecs[i].exp.len() - 1);
                $display("vec %0d: %s", i, l.text);
            end
        end

        // Back-to-back: second record waits with in_valid high.
        send(vecs[1].rec, 1'b1, acc1);
        send(vecs[2].rec, 1'b0, acc2);
        get_line(l1, ok1);
        get_line(l2, ok2);
        if (ok1 && ok2) begin
            chk_str("b2b_first",  l1.text, vecs[1].exp);
            chk_str("b2b_second", l2.text, vecs[2].exp);
            chk_int("b2b_accept_on_hash", acc2, l1.hash_cyc);
            chk_int("b2b_no_bubble", l2.first_cyc, l1.hash_cyc + 1);
            $display("b2b: %s %s", l1.text, l2.text);
        end

        // Randomized records under random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            r = rand_rec();
            send(r, 1'b0, acc);
            get_line(l, ok);
            if (ok) begin
                chk_str($sformatf("rand%0d_text", i), l.text, fmt_line(r));
                $display("rand %0d: %s", i, l.text);
            end
        end
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset after 10 characters of a line.
        send(vecs[4].rec, 1'b0, acc);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (cur.len() >= 10) break;
        end
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_int("midreset_char_valid", int'(char_valid), 0);
        chk_int("midreset_busy",       int'(busy),       0);
        chk_int("midreset_no_line",    got_lines.size(), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(vecs[0].rec, 1'b0, acc);
        get_line(l, ok);
        if (ok) begin
            chk_str("after_reset_text", l.text, vecs[0].exp);
            chk_int("after_reset_latency", l.first_cyc, acc + 1);
            $display("after reset: %s", l.text);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
